// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with main+skid output registers and writeback flush.
// Optional statistics counters are built only when RVGA_DECODE_STATS_EN is defined.
module decode_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int STAT_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifetch_decode_v,
   input  logic [DATA_W-1:0]     ifetch_decode_pc,
   input  logic [DATA_W-1:0]     ifetch_decode_instruction,
   output logic                  decode_ifetch_ready,
   input  logic                  writeback_decode_flush,
   output logic                  decode_execute_v,
   input  logic                  execute_decode_ready,
   output logic [DATA_W-1:0]     decode_execute_pc,
   output logic [6:0]            decode_execute_opcode,
   output logic [2:0]            decode_execute_funct3,
   output logic [6:0]            decode_execute_funct7,
   output logic [REG_ADDR_W-1:0] decode_execute_rs1,
   output logic [REG_ADDR_W-1:0] decode_execute_rs2,
   output logic                  decode_execute_rs1_used,
   output logic                  decode_execute_rs2_used,
   output logic [REG_ADDR_W-1:0] decode_execute_rd,
   output logic                  decode_execute_rd_we,
   output logic [DATA_W-1:0]     decode_execute_imm,
   output logic                  decode_execute_illegal,
   output logic [STAT_W-1:0]     decode_stat_insn_cnt,
   output logic [STAT_W-1:0]     decode_stat_stall_cnt
);
   typedef struct packed {
      logic [DATA_W-1:0]     pc;
      logic [6:0]            opcode;
      logic [2:0]            funct3;
      logic [6:0]            funct7;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic                  rs1_used;
      logic                  rs2_used;
      logic                  rd_we;
      logic                  illegal;
      logic [DATA_W-1:0]     imm;
   } bundle_t;

   bundle_t dec, main_q, skid_q;
   logic main_v, skid_v, in_xfer, out_xfer;
   logic known, wr, u1, u2;
   logic [DATA_W-1:0] ins, imm, imm_i, imm_s, imm_b, imm_u, imm_j;

   assign ins   = ifetch_decode_instruction;
   assign imm_i = DATA_W'($signed(ins[31:20]));
   assign imm_s = DATA_W'($signed({ins[31:25], ins[11:7]}));
   assign imm_b = DATA_W'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
   assign imm_u = DATA_W'($signed({ins[31:12], 12'b0}));
   assign imm_j = DATA_W'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

   always_comb begin
      known = 1'b0;
      wr    = 1'b0;
      u1    = 1'b0;
      u2    = 1'b0;
      imm   = '0;
      case (ins[6:0])
         7'b0110111, 7'b0010111: begin known = 1'b1; wr = 1'b1; imm = imm_u; end
         7'b1101111: begin known = 1'b1; wr = 1'b1; imm = imm_j; end
         7'b1100111: begin known = ins[14:12] == 3'b000; wr = 1'b1; u1 = 1'b1; imm = imm_i; end
         7'b0000011, 7'b0010011: begin known = 1'b1; wr = 1'b1; u1 = 1'b1; imm = imm_i; end
         7'b0100011: begin known = 1'b1; u1 = 1'b1; u2 = 1'b1; imm = imm_s; end
         7'b1100011: begin known = 1'b1; u1 = 1'b1; u2 = 1'b1; imm = imm_b; end
         7'b0110011: begin known = 1'b1; wr = 1'b1; u1 = 1'b1; u2 = 1'b1; end
         7'b0001111: known = 1'b1;
         7'b1110011: begin known = 1'b1; wr = ins[14:12] != 3'b000; end
         default: ;
      endcase
      dec          = '0;
      dec.pc       = ifetch_decode_pc;
      dec.opcode   = ins[6:0];
      dec.funct3   = ins[14:12];
      dec.funct7   = ins[31:25];
      dec.rs1      = ins[19:15];
      dec.rs2      = ins[24:20];
      dec.rd       = ins[11:7];
      dec.illegal  = !known || ins == '0 || &ins;
      dec.rd_we    = !dec.illegal && wr && ins[11:7] != '0;
      dec.rs1_used = !dec.illegal && u1;
      dec.rs2_used = !dec.illegal && u2;
      dec.imm      = dec.illegal ? '0 : imm;
   end

   assign decode_ifetch_ready = !skid_v;
   assign in_xfer  = ifetch_decode_v && !skid_v;
   assign out_xfer = main_v && execute_decode_ready;

   // Skid content always drains into main before any newer bundle is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else if (writeback_decode_flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else if (!main_v || out_xfer) begin
         main_v <= skid_v || in_xfer;
         skid_v <= 1'b0;
         if (skid_v) main_q <= skid_q;
         else if (in_xfer) main_q <= dec;
      end else if (in_xfer) begin
         skid_v <= 1'b1;
         skid_q <= dec;
      end
   end

   assign decode_execute_v        = main_v;
   assign decode_execute_pc       = main_q.pc;
   assign decode_execute_opcode   = main_q.opcode;
   assign decode_execute_funct3   = main_q.funct3;
   assign decode_execute_funct7   = main_q.funct7;
   assign decode_execute_rs1      = main_q.rs1;
   assign decode_execute_rs2      = main_q.rs2;
   assign decode_execute_rs1_used = main_q.rs1_used;
   assign decode_execute_rs2_used = main_q.rs2_used;
   assign decode_execute_rd       = main_q.rd;
   assign decode_execute_rd_we    = main_q.rd_we;
   assign decode_execute_imm      = main_q.imm;
   assign decode_execute_illegal  = main_q.illegal;

`ifdef RVGA_DECODE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         decode_stat_insn_cnt  <= '0;
         decode_stat_stall_cnt <= '0;
      end else begin
         if (out_xfer) decode_stat_insn_cnt <= decode_stat_insn_cnt + 1'b1;
         if (main_v && !execute_decode_ready) decode_stat_stall_cnt <= decode_stat_stall_cnt + 1'b1;
      end
   end
`else
   assign decode_stat_insn_cnt  = '0;
   assign decode_stat_stall_cnt = '0;
`endif
endmodule
